// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch bank controller: FSM encodings,
// operation constants and a constant-evaluable clog2 helper.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// ptr_i (with wrap-around) wins; one-hot and binary grant are both provided.
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             vld_o
);

    always_comb begin
        int j;
        gnt_o     = '0;
        gnt_idx_o = '0;
        vld_o     = 1'b0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!vld_o && req_i[j]) begin
                vld_o     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Round-robin set/clear controller for a bank of SR latches: min-width pulse,
// settle window, then one-cycle ack. Readback check enabled by SRL_VERIFY_EN.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int NUM_LATCH = 8,
    parameter  int PULSE_W   = 2,
    parameter  int SETTLE_W  = 1,
    localparam int IDX_W     = clog2(NUM_LATCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       op,
    input  logic [N_REQ*IDX_W-1:0] idx,
    output logic [N_REQ-1:0]       ack,
    output logic [NUM_LATCH-1:0]   s_out,
    output logic [NUM_LATCH-1:0]   r_out,
    input  logic [NUM_LATCH-1:0]   q_in,
    output logic                   busy,
    output logic                   err
);

    localparam int PTR_W   = clog2(N_REQ);
    localparam int CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int CNT_W   = clog2(CNT_MAX + 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [PTR_W-1:0]     rr_q;
    logic [PTR_W-1:0]     gnt_idx_q;
    logic [N_REQ-1:0]     gnt_oh_q;
    logic                 op_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_LATCH-1:0] s_out_q, r_out_q;
    logic [N_REQ-1:0]     ack_q;
    logic                 busy_q;

    logic [N_REQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]     arb_idx;
    logic                 arb_vld;
    logic                 sel_op;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_LATCH-1:0] pulse_d;
    logic [PTR_W-1:0]     rr_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i     (req),
        .ptr_i     (rr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .vld_o     (arb_vld)
    );

    assign sel_op  = op[arb_idx];
    assign sel_idx = idx[int'(arb_idx)*IDX_W +: IDX_W];
    assign rr_d    = (int'(gnt_idx_q) == N_REQ - 1) ? '0 : gnt_idx_q + PTR_W'(1);

    // Out-of-range indices decode to an empty vector, so no latch is pulsed.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_LATCH; i++)
            if (int'(sel_idx) == i) pulse_d[i] = 1'b1;
    end

`ifdef SRL_VERIFY_EN
    logic err_q;
    logic in_range;
    logic q_sel;
    assign in_range = (int'(idx_q) < NUM_LATCH);
    assign q_sel    = in_range ? q_in[idx_q] : 1'b0;
    assign err      = err_q;
`else
    logic unused_q;
    assign unused_q = ^{q_in, op_q, idx_q};
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            rr_q      <= '0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            op_q      <= OP_CLR;
            idx_q     <= '0;
            s_out_q   <= '0;
            r_out_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b1;
`ifdef SRL_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == CNT_W'(PULSE_W)) begin
                        r_out_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        r_out_q <= '1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (arb_vld) begin
                        gnt_idx_q <= arb_idx;
                        gnt_oh_q  <= arb_gnt;
                        op_q      <= sel_op;
                        idx_q     <= sel_idx;
                        s_out_q   <= (sel_op == OP_SET) ? pulse_d : '0;
                        r_out_q   <= (sel_op == OP_CLR) ? pulse_d : '0;
                        cnt_q     <= CNT_W'(1);
                        busy_q    <= 1'b1;
                        state_q   <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == CNT_W'(PULSE_W)) begin
                        s_out_q <= '0;
                        r_out_q <= '0;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_W)) begin
                        ack_q   <= gnt_oh_q;
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
`ifdef SRL_VERIFY_EN
                        if (!in_range || (q_sel != op_q)) err_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    rr_q    <= rr_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    s_out_q <= '0;
                    r_out_q <= '0;
                    ack_q   <= '0;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign s_out = s_out_q;
    assign r_out = r_out_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: transaction-level frame model plus directed
// literal checks and a randomized requester phase.
module tb_sr_latch_ctrl;

    localparam int N   = 4;
    localparam int NL  = 8;
    localparam int IW  = 3;
    localparam int PW  = 2;
    localparam int SW  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  op  = '0;
    logic [N*IW-1:0] idx = '0;
    logic [N-1:0]  ack;
    logic [NL-1:0] s_out, r_out, q_in;
    logic          busy, err;

    logic [NL-1:0] q_bank = '0;
    logic [NL-1:0] frc0   = '0;
    assign q_in = q_bank & ~frc0;

    always #5 clk = ~clk;

    sr_latch_ctrl #(.N_REQ(N), .NUM_LATCH(NL), .PULSE_W(PW), .SETTLE_W(SW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .ack(ack),
        .s_out(s_out), .r_out(r_out), .q_in(q_in), .busy(busy), .err(err)
    );

    typedef struct {
        logic [NL-1:0] s;
        logic [NL-1:0] r;
        logic [N-1:0]  a;
        logic          b;
        logic          eset;
    } frame_t;

    frame_t fq[$];
    frame_t cur;
    bit     err_m = 1'b0;
    bit     model_on = 1'b0;
    int     mrr = 0;
    int     n_cmp = 0, n_bad = 0;

    int            m_g;
    logic          m_op;
    logic [IW-1:0] m_ix;
    logic [NL-1:0] m_pv;
    logic          m_es;

    function automatic frame_t mk(logic [NL-1:0] s, logic [NL-1:0] r, logic [N-1:0] a,
                                  logic b, logic e);
        frame_t f;
        f.s = s; f.r = r; f.a = a; f.b = b; f.eset = e;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each operation expands into a fixed list of output frames.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fq.push_back(mk('0, '0, '0, 1'b1, 1'b0));
            repeat (PW) fq.push_back(mk('0, '1, '0, 1'b1, 1'b0));
            fq.push_back(mk('0, '0, '0, 1'b0, 1'b0));
            mrr = 0;
            err_m = 1'b0;
            model_on = 1'b1;
        end else if (fq.size() == 0 && req != '0) begin
            m_g = -1;
            for (int k = 0; k < N; k++)
                if (m_g < 0 && req[(mrr + k) % N]) m_g = (mrr + k) % N;
            mrr  = (m_g + 1) % N;
            m_op = op[m_g];
            m_ix = idx[m_g*IW +: IW];
            m_pv = NL'(1) << m_ix;
            m_es = frc0[m_ix] && m_op;
            repeat (PW) fq.push_back(mk(m_op ? m_pv : '0, m_op ? '0 : m_pv, '0, 1'b1, 1'b0));
            repeat (SW) fq.push_back(mk('0, '0, '0, 1'b1, 1'b0));
            fq.push_back(mk('0, '0, N'(1) << m_g, 1'b1, m_es));
            fq.push_back(mk('0, '0, '0, 1'b0, 1'b0));
        end
        if (fq.size() > 0) begin
            cur = fq.pop_front();
            if (cur.eset) err_m = 1'b1;
        end else begin
            cur = mk('0, '0, '0, 1'b0, 1'b0);
        end
    end

    // Latch bank behaviour plus the per-cycle compare against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (s_out[i])      q_bank[i] = 1'b1;
            else if (r_out[i]) q_bank[i] = 1'b0;
        end
        if (model_on) begin
            chk("s_out", 32'(s_out), 32'(cur.s));
            chk("r_out", 32'(r_out), 32'(cur.r));
            chk("ack", 32'(ack), 32'(cur.a));
            chk("busy", 32'(busy), 32'(cur.b));
`ifdef SRL_VERIFY_EN
            chk("err", 32'(err), 32'(err_m));
`else
            chk("err", 32'(err), 32'(0));
`endif
            chk("s_and_r", 32'(s_out & r_out), 32'(0));
        end
    end

    task automatic set_req(input int i, input logic o, input int ix);
        req[i] = 1'b1;
        op[i]  = o;
        idx[i*IW +: IW] = IW'(ix);
    endtask

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < 40);
        chk($sformatf("ack%0d_seen", i), 32'(ack[i]), 32'(1));
    endtask

    initial begin
        int order[5];
        int k, cyc;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        // INIT: bank cleared for PULSE_W cycles, then idle.
        @(negedge clk); chk("init_r1", 32'(r_out), 32'hFF);
        @(negedge clk); chk("init_r2", 32'(r_out), 32'hFF);
        @(negedge clk); chk("init_r3", 32'(r_out), 32'h00);
        chk("init_busy", 32'(busy), 32'(0));

        // Requester 1 sets latch 5.
        set_req(1, 1'b1, 5);
        @(negedge clk); chk("set5_p1", 32'(s_out), 32'h20);
        @(negedge clk); chk("set5_p2", 32'(s_out), 32'h20);
        @(negedge clk); chk("set5_settle", 32'(s_out), 32'h00);
        @(negedge clk); chk("set5_ack", 32'(ack), 32'b0010);
        chk("set5_q", 32'(q_in[5]), 32'(1));
        req[1] = 1'b0;

        // Requester 2 clears latch 5.
        set_req(2, 1'b0, 5);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (r_out == '0 && cyc < 20);
        chk("clr5_r", 32'(r_out), 32'h20);
        wait_ack(2);
        req[2] = 1'b0;
        chk("clr5_q", 32'(q_in[5]), 32'(0));

        // Held requests from pointer 0 after reset.
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req = 4'b1111;
        k = 0; cyc = 0;
        while (k < 5 && cyc < 100) begin
            @(negedge clk); cyc++;
            for (int i = 0; i < N; i++)
                if (ack[i] && k < 5) begin order[k] = i; k++; end
        end
        req = '0;
        chk("lap_count", 32'(k), 32'(5));
        chk("lap0", 32'(order[0]), 32'(0));
        chk("lap1", 32'(order[1]), 32'(1));
        chk("lap2", 32'(order[2]), 32'(2));
        chk("lap3", 32'(order[3]), 32'(3));
        chk("lap4", 32'(order[4]), 32'(0));

        // Reset mid-pulse: pointer (now 1) must return to 0.
        set_req(2, 1'b1, 2);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (s_out == '0 && cyc < 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_s", 32'(s_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_ack", 32'(ack), 32'(0));
        rst = 1'b0;
        set_req(0, 1'b0, 1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ack == '0 && cyc < 40);
        chk("rst_ptr_grant", 32'(ack), 32'b0001);
        req[0] = 1'b0;
        wait_ack(2);
        req[2] = 1'b0;

        // Readback mismatch on latch 3.
        frc0 = 8'h08;
        set_req(3, 1'b1, 3);
        wait_ack(3);
        req[3] = 1'b0;
`ifdef SRL_VERIFY_EN
        chk("err_set", 32'(err), 32'(1));
`else
        chk("err_set", 32'(err), 32'(0));
`endif
        repeat (3) @(negedge clk);
`ifdef SRL_VERIFY_EN
        chk("err_sticky", 32'(err), 32'(1));
`else
        chk("err_sticky", 32'(err), 32'(0));
`endif
        frc0 = '0;

        // Randomized requesters with occasional reset and forced readback.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(3) == 0)
                    set_req(i, 1'($urandom_range(1)), int'($urandom_range(NL - 1)));
                else if ($urandom_range(7) == 0) begin
                    op[i] = 1'($urandom_range(1));
                    idx[i*IW +: IW] = IW'($urandom_range(NL - 1));
                end
            end
            if (!busy && $urandom_range(31) == 0) frc0 = NL'($urandom) & 8'h91;
            if ($urandom_range(499) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
